traffic_countdown: RTL and testbench

Phase sequencer and countdown source for one traffic-light head. It cycles RED → GREEN → YELLOW → RED, counting each phase down once per second. It drives the `number`/`en` pair consumed by the 7-segment counter decoder, plus the lamp outputs. It sits between the board clock and the display decoder and owns all traffic-light timing.

---
 rtl/traffic_pkg.sv | 43 ++++
 rtl/traffic_countdown_tick_gen.sv | 33 +++
 rtl/traffic_countdown.sv | 127 ++++++++++++
 tb/tb_traffic_countdown.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light phase sequencer.
// Phase enum, lamp encodings {red, yellow, green} and phase-order helpers.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RED    = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } phase_e;

    localparam logic [2:0] LIGHT_OFF    = 3'b000;
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam int MAX_PHASE_TIME = 19;

    function automatic phase_e nextPhase(input phase_e p);
        phase_e n;
        n = IDLE;
        case (p)
            RED:     n = GREEN;
            GREEN:   n = YELLOW;
            YELLOW:  n = RED;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] lightOf(input phase_e p);
        logic [2:0] l;
        l = LIGHT_OFF;
        case (p)
            RED:     l = LIGHT_RED;
            GREEN:   l = LIGHT_GREEN;
            YELLOW:  l = LIGHT_YELLOW;
            default: l = LIGHT_OFF;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_countdown_tick_gen.sv
// Prescaler that divides the board clock down to the one-per-second tick.
// Clear forces it back to zero; hold freezes the count and masks the tick.
module tick_gen #(
    parameter int pTICK_DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_tick
);

    localparam int CNT_W = (pTICK_DIV > 1) ? $clog2(pTICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(pTICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (!i_hold) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + ONE;
            end
        end
    end

    assign o_tick = (r_count == LAST) && !i_hold;

endmodule

// File: rtl/traffic_countdown.sv
// Traffic-light head sequencer: RED -> GREEN -> YELLOW -> RED, each phase
// counted down once per tick, with registered number/en/light/phase_done outputs.
module traffic_countdown
    import traffic_pkg::*;
#(
    parameter int pNUMBER_WIDTH = 5,
    parameter int pRED_TIME     = 15,
    parameter int pGREEN_TIME   = 12,
    parameter int pYELLOW_TIME  = 3,
    parameter int pTICK_DIV     = 50_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_hold,
    output logic [pNUMBER_WIDTH-1:0] o_number,
    output logic                     o_en,
    output logic [2:0]               o_light,
    output logic                     o_phase_done
);

    localparam int MAX_BY_WIDTH = (2 ** pNUMBER_WIDTH) - 1;

    if (pRED_TIME < 1 || pRED_TIME > MAX_PHASE_TIME || pRED_TIME > MAX_BY_WIDTH ||
        pGREEN_TIME < 1 || pGREEN_TIME > MAX_PHASE_TIME || pGREEN_TIME > MAX_BY_WIDTH ||
        pYELLOW_TIME < 1 || pYELLOW_TIME > MAX_PHASE_TIME || pYELLOW_TIME > MAX_BY_WIDTH ||
        pTICK_DIV < 1) begin : gBadParams
        $fatal(1, "traffic_countdown: illegal phase duration or tick divider");
    end

    localparam logic [pNUMBER_WIDTH-1:0] LOAD_RED    = pNUMBER_WIDTH'(pRED_TIME - 1);
    localparam logic [pNUMBER_WIDTH-1:0] LOAD_GREEN  = pNUMBER_WIDTH'(pGREEN_TIME - 1);
    localparam logic [pNUMBER_WIDTH-1:0] LOAD_YELLOW = pNUMBER_WIDTH'(pYELLOW_TIME - 1);
    localparam logic [pNUMBER_WIDTH-1:0] NUM_ONE     = pNUMBER_WIDTH'(1);

    phase_e                     r_state;
    phase_e                     w_next_state;
    logic [pNUMBER_WIDTH-1:0]   r_number;
    logic [pNUMBER_WIDTH-1:0]   w_next_number;
    logic                       r_en;
    logic [2:0]                 r_light;
    logic                       r_phase_done;
    logic                       w_next_phase_done;
    logic                       w_tick;
    logic                       w_clear;

    // Prescaler sits at zero throughout IDLE so RED always starts a full tick period.
    assign w_clear = (r_state == IDLE);

    tick_gen #(
        .pTICK_DIV (pTICK_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_clear),
        .i_hold  (i_hold),
        .o_tick  (w_tick)
    );

    function automatic logic [pNUMBER_WIDTH-1:0] loadFor(input phase_e p);
        logic [pNUMBER_WIDTH-1:0] v;
        v = '0;
        case (p)
            RED:     v = LOAD_RED;
            GREEN:   v = LOAD_GREEN;
            YELLOW:  v = LOAD_YELLOW;
            default: v = '0;
        endcase
        return v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_number     <= '0;
            r_en         <= 1'b0;
            r_light      <= LIGHT_OFF;
            r_phase_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_number     <= w_next_number;
            r_en         <= (w_next_state != IDLE);
            r_light      <= lightOf(w_next_state);
            r_phase_done <= w_next_phase_done;
        end
    end

    // Hold needs no branch here: it already masks the tick, freezing everything.
    always_comb begin
        w_next_state      = r_state;
        w_next_number     = r_number;
        w_next_phase_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && !i_stop) begin
                    w_next_state  = RED;
                    w_next_number = LOAD_RED;
                end
            end
            RED, GREEN, YELLOW: begin
                if (i_stop) begin
                    w_next_state  = IDLE;
                    w_next_number = '0;
                end else if (w_tick) begin
                    if (r_number != '0) begin
                        w_next_number = r_number - NUM_ONE;
                    end else begin
                        w_next_state      = nextPhase(r_state);
                        w_next_number     = loadFor(nextPhase(r_state));
                        w_next_phase_done = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state  = IDLE;
                w_next_number = '0;
            end
        endcase
    end

    assign o_number     = r_number;
    assign o_en         = r_en;
    assign o_light      = r_light;
    assign o_phase_done = r_phase_done;

endmodule

// File: tb/tb_traffic_countdown.sv
// Scoreboard bench for traffic_countdown with a 4-cycle tick and 3/2/1 phase lengths,
// so one RED/GREEN/YELLOW loop is 12+8+4 = 24 cycles.
module tb_traffic_countdown;

   typedef struct {
      logic [4:0] number;
      logic       en;
      logic [2:0] light;
      logic       pd;
      string      name;
   } expT;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       hold;
   logic [4:0] number;
   logic       en;
   logic [2:0] light;
   logic       phaseDone;

   expT expQ[$];
   int  checkCount = 0;
   int  errorCount = 0;
   int  tl;

   traffic_countdown #(
      .pNUMBER_WIDTH (5),
      .pRED_TIME     (3),
      .pGREEN_TIME   (2),
      .pYELLOW_TIME  (1),
      .pTICK_DIV     (4)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_stop       (stop),
      .i_hold       (hold),
      .o_number     (number),
      .o_en         (en),
      .o_light      (light),
      .o_phase_done (phaseDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs t cycles after RED entry, from the 12/8/4 phase timeline.
   function automatic expT timelineExp(input int t, input string nm);
      expT e;
      int  p;
      p = t % 24;
      e.en = 1'b1;
      e.name = nm;
      if (p < 12) begin
         e.light  = 3'b100;
         e.number = 5'(2 - p / 4);
      end else if (p < 20) begin
         e.light  = 3'b001;
         e.number = 5'(1 - (p - 12) / 4);
      end else begin
         e.light  = 3'b010;
         e.number = 5'd0;
      end
      e.pd = (t > 0) && (p == 0 || p == 12 || p == 20);
      return e;
   endfunction

   function automatic expT idleExp(input string nm);
      expT e;
      e.number = 5'd0;
      e.en     = 1'b0;
      e.light  = 3'b000;
      e.pd     = 1'b0;
      e.name   = nm;
      return e;
   endfunction

   // Drive one cycle of inputs and queue what the outputs must be after the next edge.
   task automatic applyStimulus(input logic st, input logic sp, input logic hd,
                                input logic rs, input expT e);
      @(negedge clk);
      start = st;
      stop  = sp;
      hold  = hd;
      rst   = rs;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input expT e);
      checkCount++;
      if (number !== e.number || en !== e.en || light !== e.light || phaseDone !== e.pd) begin
         errorCount++;
         $display("[TB] FAIL %s: got number=%0d en=%b light=%b pd=%b, want number=%0d en=%b light=%b pd=%b",
                  e.name, number, en, light, phaseDone, e.number, e.en, e.light, e.pd);
      end
   endtask

   // Monitor: one registered output set appears per edge; compare it against the queue head.
   always @(posedge clk) begin
      expT e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput(e);
      end
   end

   task automatic runTo(input int tEnd, input string nm);
      while (tl < tEnd) begin
         tl++;
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, timelineExp(tl, nm));
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b1;
      stop  = 1'b0;
      hold  = 1'b0;
      tl    = 0;

      $display("[TB] reset with start held");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, idleExp("reset"));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, idleExp("after_reset"));

      $display("[TB] start, RED countdown and three full loops");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, timelineExp(0, "red_entry"));
      runTo(72, "loop");

      $display("[TB] hold mid-GREEN at number=1, prescaler=2");
      runTo(86, "to_hold");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, timelineExp(86, "hold_frozen"));
      runTo(95, "after_hold");

      $display("[TB] stop on YELLOW terminal tick, start+stop in IDLE");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, idleExp("stop_on_tick"));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, idleExp("idle_after_stop"));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, idleExp("start_and_stop"));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, idleExp("still_idle"));

      $display("[TB] reset mid-RED then restart");
      tl = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, timelineExp(0, "restart"));
      runTo(4, "red_again");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, idleExp("reset_mid_red"));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, idleExp("idle_after_rst"));
      tl = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, timelineExp(0, "fresh_start"));
      runTo(13, "post_reset_run");

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      if (expQ.size() > 0) begin
         errorCount++;
         $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
